// File: rtl/core_pkg.sv
// Shared definitions for the commit stage: wselector bit positions, FSM states, named registers.
package core_pkg;
  localparam int WSEL_PC  = 2;
  localparam int WSEL_REG = 1;
  localparam int WSEL_FLT = 0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } wb_state_e;

  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/regfile32.sv
// 32x32 register file, one synchronous write port, two combinational read ports.
// WB_BYPASS_EN makes reads of the register being written return the incoming data.
module regfile32
  import core_pkg::*;
#(
  parameter bit          ZERO_R0 = 1'b1,
  parameter logic [31:0] SP_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= (5'(i) == REG_SP) ? SP_INIT : 32'h0;
      end
    end else if (we && !(ZERO_R0 && waddr == 5'd0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The r0 rule is checked first so bypass can never leak a dropped write.
`ifdef WB_BYPASS_EN
  assign rdata_a = (ZERO_R0 && raddr_a == 5'd0) ? 32'h0 :
                   (we && waddr == raddr_a)     ? wdata : mem_q[raddr_a];
  assign rdata_b = (ZERO_R0 && raddr_b == 5'd0) ? 32'h0 :
                   (we && waddr == raddr_b)     ? wdata : mem_q[raddr_b];
`else
  assign rdata_a = (ZERO_R0 && raddr_a == 5'd0) ? 32'h0 : mem_q[raddr_a];
  assign rdata_b = (ZERO_R0 && raddr_b == 5'd0) ? 32'h0 : mem_q[raddr_b];
`endif
endmodule

// File: rtl/write_back.sv
// Commit stage: owns GPR/FPR files and the PC, sequences one instruction at a time via fetch_enable.
// Optional macro WB_BYPASS_EN enables write-through on the read ports.
module write_back
  import core_pkg::*;
#(
  parameter logic [31:0] START_PC = 32'h0,
  parameter logic [31:0] SP_INIT  = 32'h000f_fff0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        done,
  input  logic [2:0]  wselector,
  input  logic [31:0] data,
  input  logic [4:0]  rd,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic [4:0]  rs_no,
  input  logic [4:0]  rt_no,
  input  logic        fmode1,
  input  logic        fmode2,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic        fetch_enable,
  output logic        err
);
  wb_state_e   state_q;
  logic [31:0] pc_q, pc_d;
  logic        fe_q, err_q;
  logic        commit, gpr_we, fpr_we;
  logic [31:0] gpr_a, gpr_b, fpr_a, fpr_b;

  // Gated by rstn so a reset edge never lets a pending commit through, bypass included.
  assign commit = rstn && (state_q == WAIT) && done && !stall;
  assign gpr_we = commit && wselector[WSEL_REG] && !wselector[WSEL_FLT];
  assign fpr_we = commit && wselector[WSEL_REG] &&  wselector[WSEL_FLT];

  always_comb begin
    pc_d = pc_q;
    if (state_q == WAIT) begin
      if (stall) begin
        pc_d = pc_in;
      end else if (done) begin
        pc_d = wselector[WSEL_PC] ? {pc_in[31:2], 2'b00} : pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BOOT;
      pc_q    <= START_PC;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fe_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          fe_q    <= 1'b1;
          if (done || stall) err_q <= 1'b1;
        end
        FETCH: begin
          state_q <= WAIT;
          if (done || stall) err_q <= 1'b1;
        end
        WAIT: begin
          if (done || stall) begin
            state_q <= FETCH;
            fe_q    <= 1'b1;
            if (commit && wselector[WSEL_PC] && pc_in[1:0] != 2'b00) err_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  regfile32 #(.ZERO_R0(1'b1), .SP_INIT(SP_INIT)) u_gpr (
    .clk(clk), .rstn(rstn), .we(gpr_we), .waddr(rd), .wdata(data),
    .raddr_a(rs_no), .raddr_b(rt_no), .rdata_a(gpr_a), .rdata_b(gpr_b)
  );

  regfile32 #(.ZERO_R0(1'b0), .SP_INIT(32'h0)) u_fpr (
    .clk(clk), .rstn(rstn), .we(fpr_we), .waddr(rd), .wdata(data),
    .raddr_a(rs_no), .raddr_b(rt_no), .rdata_a(fpr_a), .rdata_b(fpr_b)
  );

  assign rs_data      = fmode1 ? fpr_a : gpr_a;
  assign rt_data      = fmode2 ? fpr_b : gpr_b;
  assign pc           = pc_q;
  assign fetch_enable = fe_q;
  assign err          = err_q;
endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed table, hand sequences for bypass/reset/alignment, then random vs model.
module tb_write_back;
  localparam logic [31:0] SPC = 32'h100;
  localparam logic [31:0] SPI = 32'h000f_fff0;

  logic        clk = 1'b0;
  logic        rstn, done, stall, fmode1, fmode2, fetch_enable, err;
  logic [2:0]  wselector;
  logic [31:0] data, pc_in, rs_data, rt_data, pc;
  logic [4:0]  rd, rs_no, rt_no;

  int checks = 0;
  int errors = 0;

  write_back #(.START_PC(SPC), .SP_INIT(SPI)) dut (
    .clk(clk), .rstn(rstn), .done(done), .wselector(wselector), .data(data),
    .rd(rd), .pc_in(pc_in), .stall(stall), .rs_no(rs_no), .rt_no(rt_no),
    .fmode1(fmode1), .fmode2(fmode2), .rs_data(rs_data), .rt_data(rt_data),
    .pc(pc), .fetch_enable(fetch_enable), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s, input logic [2:0] ws, input logic [31:0] dt,
                       input logic [4:0] r, input logic [31:0] pci);
    done = d; stall = s; wselector = ws; data = dt; rd = r; pc_in = pci;
  endtask

  typedef struct {
    logic        dn, st;
    logic [2:0]  ws;
    logic [31:0] dat;
    logic [4:0]  rd;
    logic [31:0] pci;
    logic [4:0]  rsn;
    logic        fm;
    logic [31:0] e_pc;
    logic        e_fe, e_err;
    logic [31:0] e_rs;
  } vec_t;

  vec_t tbl[18];

  // Reference model: architectural register/PC state and a phase counter for the one-at-a-time protocol.
  logic [31:0] gm[32], fm[32];
  logic [31:0] m_pc;
  logic        m_fe, m_err;
  int          m_ph;  // 0: just out of reset, 1: fetch requested, 2: awaiting result

  task automatic model_step(input logic r, input logic d, input logic s, input logic [2:0] ws,
                            input logic [31:0] dt, input logic [4:0] rdn, input logic [31:0] pci);
    if (!r) begin
      for (int i = 0; i < 32; i++) begin gm[i] = 0; fm[i] = 0; end
      gm[29] = SPI; m_pc = SPC; m_ph = 0; m_fe = 0; m_err = 0;
    end else if (m_ph == 0 || m_ph == 1) begin
      if (d || s) m_err = 1;
      m_fe = (m_ph == 0);
      m_ph = m_ph + 1;
    end else if (s) begin
      m_pc = pci; m_ph = 1; m_fe = 1;
    end else if (d) begin
      if (ws[1] && ws[0]) fm[rdn] = dt;
      else if (ws[1] && rdn != 0) gm[rdn] = dt;
      if (ws[2]) begin
        if (pci % 4 != 0) m_err = 1;
        m_pc = pci - (pci % 4);
      end else begin
        m_pc = m_pc + 4;
      end
      m_ph = 1; m_fe = 1;
    end else begin
      m_fe = 0;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] n, input logic f, input logic pend,
                                           input logic pf, input logic [4:0] pr, input logic [31:0] pd);
    if (!f && n == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (pend && pf == f && pr == n) return pd;
`endif
    return f ? fm[n] : gm[n];
  endfunction

  initial begin
    rstn = 0; rs_no = 0; rt_no = 0; fmode1 = 0; fmode2 = 0;
    drive(0, 0, 3'b000, 0, 0, 0);

    //   dn st ws      dat           rd  pci         rsn fm e_pc       fe err e_rs
    tbl[0]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,   29, 0, 32'h100, 1, 0, 32'h000f_fff0};
    tbl[1]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,   29, 0, 32'h100, 0, 0, 32'h000f_fff0};
    tbl[2]  = '{1, 0, 3'b010, 32'hDEADBEEF, 5, 32'h0,    5, 0, 32'h104, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    5, 0, 32'h104, 0, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 0, 3'b011, 32'h3F800000, 0, 32'h0,    0, 1, 32'h108, 1, 0, 32'h3F800000};
    tbl[5]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    0, 0, 32'h108, 0, 0, 32'h0};
    tbl[6]  = '{1, 0, 3'b010, 32'h12345678, 0, 32'h0,    0, 0, 32'h10c, 1, 0, 32'h0};
    tbl[7]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    0, 1, 32'h10c, 0, 0, 32'h3F800000};
    tbl[8]  = '{1, 0, 3'b110, 32'h108,     31, 32'h200, 31, 0, 32'h200, 1, 0, 32'h108};
    tbl[9]  = '{0, 0, 3'b000, 32'h0,        0, 32'h0,   31, 0, 32'h200, 0, 0, 32'h108};
    tbl[10] = '{1, 1, 3'b010, 32'h55,       6, 32'h104,  6, 0, 32'h104, 1, 0, 32'h0};
    tbl[11] = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    6, 0, 32'h104, 0, 0, 32'h0};
    tbl[12] = '{1, 0, 3'b000, 32'h99,       7, 32'h0,    7, 0, 32'h108, 1, 0, 32'h0};
    tbl[13] = '{1, 0, 3'b010, 32'hAA,       8, 32'h0,    8, 0, 32'h108, 0, 1, 32'h0};
    tbl[14] = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    8, 0, 32'h108, 0, 1, 32'h0};
    tbl[15] = '{1, 0, 3'b010, 32'h77,       7, 32'h0,    7, 0, 32'h10c, 1, 1, 32'h77};
    tbl[16] = '{0, 0, 3'b000, 32'h0,        0, 32'h0,    7, 0, 32'h10c, 0, 1, 32'h77};
    tbl[17] = '{1, 0, 3'b100, 32'h0,        0, 32'h303,  7, 0, 32'h300, 1, 1, 32'h77};

    cyc(); cyc(); cyc();
    rs_no = 29;
    #1;
    chk("reset_pc", pc, SPC);
    chk("reset_fe", 32'(fetch_enable), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_sp", rs_data, SPI);

    rstn = 1;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].dn, tbl[i].st, tbl[i].ws, tbl[i].dat, tbl[i].rd, tbl[i].pci);
      rs_no = tbl[i].rsn; fmode1 = tbl[i].fm;
      cyc();
      chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d_fe", i), 32'(fetch_enable), 32'(tbl[i].e_fe));
      chk($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d_rs", i), rs_data, tbl[i].e_rs);
    end

    // Same-edge read of the register being committed.
    drive(0, 0, 3'b000, 0, 0, 0);
    cyc();
    drive(1, 0, 3'b010, 32'h1234, 7, 0);
    rs_no = 7; fmode1 = 0;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_same_cycle", rs_data, 32'h1234);
`else
    chk("bypass_same_cycle", rs_data, 32'h77);
`endif
    cyc();
    drive(0, 0, 3'b000, 0, 0, 0);
    chk("bypass_next_cycle", rs_data, 32'h1234);

    // Reset clears state; then a misaligned PC write is truncated and flagged.
    rstn = 0; rt_no = 7; fmode2 = 0; rs_no = 29;
    cyc();
    chk("rst2_err", 32'(err), 0);
    chk("rst2_pc", pc, SPC);
    chk("rst2_r7", rt_data, 0);
    chk("rst2_sp", rs_data, SPI);
    rstn = 1;
    cyc();
    chk("rst2_fe_boot", 32'(fetch_enable), 1);
    cyc();
    chk("rst2_fe_wait", 32'(fetch_enable), 0);
    drive(1, 0, 3'b100, 0, 0, 32'h202);
    cyc();
    drive(0, 0, 3'b000, 0, 0, 0);
    chk("misalign_pc", pc, 32'h200);
    chk("misalign_err", 32'(err), 1);

    // Random traffic against the model.
    for (int it = 0; it < 600; it++) begin
      logic r, d, s, f1, f2, pend;
      logic [2:0] ws;
      logic [4:0] rdn, a, b;
      logic [31:0] dt, pci;
      r   = (it == 0) ? 1'b0 : ($urandom_range(0, 70) != 0);
      d   = (m_ph == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      s   = ($urandom_range(0, 7) == 0) && (m_ph == 2 || $urandom_range(0, 3) == 0);
      ws  = 3'($urandom_range(0, 7));
      rdn = 5'($urandom_range(0, 31));
      dt  = $urandom;
      pci = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hffff_fffc);
      a   = ($urandom_range(0, 2) == 0) ? rdn : 5'($urandom_range(0, 31));
      b   = 5'($urandom_range(0, 31));
      f1  = 1'($urandom_range(0, 1));
      f2  = 1'($urandom_range(0, 1));
      rstn = r; drive(d, s, ws, dt, rdn, pci);
      rs_no = a; rt_no = b; fmode1 = f1; fmode2 = f2;
      #1;
      pend = r && (m_ph == 2) && d && !s && ws[1];
      if (r) begin
        chk("rnd_rs", rs_data, exp_read(a, f1, pend, ws[0], rdn, dt));
        chk("rnd_rt", rt_data, exp_read(b, f2, pend, ws[0], rdn, dt));
      end
      model_step(r, d, s, ws, dt, rdn, pci);
      cyc();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_fe", 32'(fetch_enable), 32'(m_fe));
      chk("rnd_err", 32'(err), 32'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Commit stage directly downstream of the execute unit. It consumes the execute unit's done / wselector / data / rd / pc_out / stall_enable outputs.
- Owns the integer (GPR) and float (FPR) register files and the architectural PC.
- Provides the register read ports used by decode.
- Sequences the core one instruction at a time by pulsing fetch_enable after each commit.

Parameters:
- START_PC, 32'h0: PC value loaded at reset.
- SP_INIT, 32'h000f_fff0: reset value of GPR r29. All other registers reset to 0.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- done  in  1  execute-complete pulse
- wselector  in  3  bit2 = PC write; bit1 = register write; bit0 = 1 selects FPR, 0 selects GPR
- data  in  32  result to write
- rd  in  5  destination register number
- pc_in  in  32  branch/jump target, or restart PC on stall
- stall  in  1  execute rejected the instruction; restart at pc_in
- rs_no  in  5  read port A register number
- rt_no  in  5  read port B register number
- fmode1  in  1  port A reads FPR when 1
- fmode2  in  1  port B reads FPR when 1
- rs_data  out  32  port A data (combinational)
- rt_data  out  32  port B data (combinational)
- pc  out  32  architectural PC
- fetch_enable  out  1  one-cycle request to fetch at pc
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rstn=0 at posedge):
  - pc=START_PC; GPR r29=SP_INIT; all other GPR/FPR entries=0.
  - fetch_enable=0, err=0, state=BOOT.
- Clock and reset: single clock clk; reset is synchronous and active-low (rstn). Reset mid-instruction discards any pending commit.
- FSM states: BOOT, FETCH, WAIT.
  - BOOT: one cycle after reset release -> FETCH.
  - FETCH: fetch_enable=1 for exactly this cycle -> WAIT.
  - WAIT: hold until done or stall.
    - On the edge where done=1 and stall=0, commit, then -> FETCH.
    - On the edge where stall=1 (done may also be 1), no register write; pc<=pc_in; -> FETCH.
- Commit:
  - If wselector[1]=1, write data to FPR[rd] when wselector[0]=1, else to GPR[rd].
  - A GPR write with rd=0 is dropped; GPR r0 always reads 0. FPR f0 is writable.
  - pc <= wselector[2] ? pc_in : pc+4. The +4 wraps modulo 2^32.
  - Latency: done at edge N gives register/pc update visible after N and fetch_enable high in cycle N+1.
- wselector=000 with done=1 (stores, OUT): pc+4 only, no register write.
- Read ports:
  - rs_data = fmode1 ? FPR[rs_no] : (rs_no==0 ? 0 : GPR[rs_no]).
  - rt_data is the same using rt_no and fmode2.
  - Pure array reads, no bypass, except as described under Optional Feature.
- Protocol errors:
  - done or stall asserted in BOOT or FETCH sets err=1 (sticky until reset); the event is otherwise ignored.
  - pc_in[1:0]!=0 on a PC write also sets err; pc takes {pc_in[31:2],2'b00}.
- Only one commit per fetch. Back-to-back done pulses in consecutive cycles: the second falls in FETCH and sets err.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: a read whose register and file match the write being committed on the current edge returns data combinationally (write-through). The r0 rule still takes priority.
- When undefined: reads return pre-edge array contents; the new value is visible from the next cycle.

Decomposition:
- Shared package core_pkg holds:
  - WSEL_PC=2, WSEL_REG=1, WSEL_FLT=0 bit indices
  - state encoding BOOT/FETCH/WAIT
  - REG_SP=5'd29, REG_RA=5'd31
- Sub-module regfile32: 32x32 array, one write port, two read ports, zero-reg enable parameter. Instantiated twice (GPR with ZERO_R0=1, FPR with ZERO_R0=0); write_back contains the FSM and PC.

Test Plan:
1. Reset with START_PC=32'h100 -> pc=0x100; fetch_enable high exactly in the 2nd cycle after rstn rises; rs_no=29 reads 0x000f_fff0.
2. WAIT, done=1, wselector=010, rd=5, data=0xDEAD_BEEF -> GPR5=0xDEAD_BEEF read on port A next cycle; pc 0x100->0x104; fetch_enable pulse.
3. done, wselector=011, rd=0, data=0x3F80_0000 -> FPR0=0x3F80_0000; GPR0 still reads 0. Repeat with wselector=010, rd=0 -> GPR0 stays 0.
4. done, wselector=110, rd=31, data=0x108, pc_in=0x200 -> GPR31=0x108, pc=0x200.
5. done=1 and stall=1 same cycle, pc_in=0x104, wselector=010 -> no register write, pc=0x104, fetch_enable next cycle, err=0.
6. done pulsed in FETCH -> err=1 and stays set. With WB_BYPASS_EN, a commit rd=7 with rs_no=7 returns data in the same cycle; without it, the old value is returned.
